// File: rtl/sdram_bram_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sdram_bram_responder_pkg
// Brief    : Shared bus widths and operation type for the BRAM-backed
//            SDRAM responder and the board-level bus bridge.
// Revision : 1.0 - initial release
// ============================================================================
package sdram_bram_responder_pkg;

    localparam int SDRAM_AW = 22;
    localparam int SDRAM_DW = 16;

    typedef enum logic {
        OP_WR = 1'b0,
        OP_RD = 1'b1
    } op_e;

endpackage
`default_nettype wire

// File: rtl/sdram_bram_responder_bram_be16.sv
`default_nettype none
// ============================================================================
// Module   : bram_be16
// Brief    : Single-port synchronous RAM, 16-bit words, per-byte write
//            enables, registered read (1-cycle latency, read-first).
// Revision : 1.0 - initial release
// ============================================================================
module bram_be16
    import sdram_bram_responder_pkg::*;
#(
    parameter int ADDR_BITS = 14
) (
    input  logic                 clk,
    input  logic                 i_en,
    input  logic [1:0]           i_we,
    input  logic [ADDR_BITS-1:0] i_addr,
    input  logic [SDRAM_DW-1:0]  i_wdata,
    output logic [SDRAM_DW-1:0]  o_rdata
);

    logic [SDRAM_DW-1:0] r_mem [0:(1<<ADDR_BITS)-1];
    logic [SDRAM_DW-1:0] r_rdata_q;

    // No reset on the array or read register so both vendors map this to BRAM.
    always_ff @(posedge clk) begin
        if (i_en) begin
            for (int b = 0; b < 2; b++) begin
                if (i_we[b]) begin
                    r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
            r_rdata_q <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata_q;

endmodule
`default_nettype wire

// File: rtl/sdram_bram_responder.sv
`default_nettype none
// ============================================================================
// Module   : sdram_bram_responder
// Brief    : Drop-in replacement for sdram_top that serves the system-side
//            request/ack protocol from on-chip block RAM.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_bram_responder
    import sdram_bram_responder_pkg::*;
#(
    parameter int ADDR_BITS   = 14,
    parameter int INIT_CYCLES = 200,
    parameter int LATENCY     = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sdram_wr_req,
    input  logic                sdram_rd_req,
    output logic                sdram_wr_ack,
    output logic                sdram_rd_ack,
    input  logic [1:0]          sdram_byteenable,
    input  logic [SDRAM_AW-1:0] sys_wraddr,
    input  logic [SDRAM_AW-1:0] sys_rdaddr,
    input  logic [SDRAM_DW-1:0] sys_data_in,
    output logic [SDRAM_DW-1:0] sys_data_out,
    output logic                sdram_init_done
);

    localparam logic [2:0] ST_INIT = 3'd0;
    localparam logic [2:0] ST_IDLE = 3'd1;
    localparam logic [2:0] ST_BUSY = 3'd2;
    localparam logic [2:0] ST_ACK  = 3'd3;
    localparam logic [2:0] ST_HOLD = 3'd4;

    localparam int c_init_w = $clog2(INIT_CYCLES + 1);
    localparam int c_lat_w  = $clog2(LATENCY);
    localparam logic [c_init_w-1:0] c_init_last = c_init_w'(INIT_CYCLES);
    localparam logic [c_lat_w-1:0]  c_lat_last  = c_lat_w'(LATENCY - 2);

    logic [2:0]           r_state_q,     w_state_d;
    logic [c_init_w-1:0]  r_init_cnt_q,  w_init_cnt_d;
    logic [c_lat_w-1:0]   r_lat_cnt_q,   w_lat_cnt_d;
    op_e                  r_op_q,        w_op_d;
    logic [ADDR_BITS-1:0] r_addr_q,      w_addr_d;
    logic [SDRAM_DW-1:0]  r_wdata_q,     w_wdata_d;
    logic [1:0]           r_be_q,        w_be_d;
    logic                 r_wr_ack_q,    w_wr_ack_d;
    logic                 r_rd_ack_q,    w_rd_ack_d;
    logic                 r_init_done_q, w_init_done_d;
    logic [SDRAM_DW-1:0]  r_data_out_q,  w_data_out_d;

    logic                 w_ram_en;
    logic [1:0]           w_ram_we;
    logic [SDRAM_DW-1:0]  w_ram_rdata;

    generate
        if (ADDR_BITS < SDRAM_AW) begin : g_addr_alias
            // Upper address bits are deliberately dropped: addresses alias modulo depth.
            logic w_unused_addr_bits;
            assign w_unused_addr_bits = ^{sys_wraddr[SDRAM_AW-1:ADDR_BITS],
                                          sys_rdaddr[SDRAM_AW-1:ADDR_BITS]};
        end
    endgenerate

    always_comb begin
        w_state_d     = r_state_q;
        w_init_cnt_d  = r_init_cnt_q;
        w_lat_cnt_d   = r_lat_cnt_q;
        w_op_d        = r_op_q;
        w_addr_d      = r_addr_q;
        w_wdata_d     = r_wdata_q;
        w_be_d        = r_be_q;
        w_wr_ack_d    = 1'b0;
        w_rd_ack_d    = 1'b0;
        w_init_done_d = r_init_done_q;
        w_data_out_d  = r_data_out_q;

        case (r_state_q)
            ST_INIT: begin
                if (r_init_cnt_q == c_init_last) begin
                    w_state_d     = ST_IDLE;
                    w_init_done_d = 1'b1;
                end else begin
                    w_init_cnt_d = r_init_cnt_q + c_init_w'(1);
                end
            end
            ST_IDLE: begin
                w_lat_cnt_d = '0;
                if (sdram_wr_req) begin
                    w_op_d    = OP_WR;
                    w_addr_d  = sys_wraddr[ADDR_BITS-1:0];
                    w_wdata_d = sys_data_in;
                    w_be_d    = sdram_byteenable;
                    w_state_d = ST_BUSY;
                end else if (sdram_rd_req) begin
                    w_op_d    = OP_RD;
                    w_addr_d  = sys_rdaddr[ADDR_BITS-1:0];
                    w_state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (r_lat_cnt_q == c_lat_last) begin
                    w_state_d = ST_ACK;
                end else begin
                    w_lat_cnt_d = r_lat_cnt_q + c_lat_w'(1);
                end
            end
            ST_ACK: begin
                if (r_op_q == OP_WR) begin
                    w_wr_ack_d = 1'b1;
                end else begin
                    w_rd_ack_d   = 1'b1;
                    w_data_out_d = w_ram_rdata;
                end
                w_state_d = ST_HOLD;
            end
            ST_HOLD: begin
                // Bridge keeps its request up briefly after the ack; wait it out.
                if ((r_op_q == OP_WR && !sdram_wr_req) ||
                    (r_op_q == OP_RD && !sdram_rd_req)) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: w_state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_q     <= ST_INIT;
            r_init_cnt_q  <= '0;
            r_lat_cnt_q   <= '0;
            r_op_q        <= OP_WR;
            r_addr_q      <= '0;
            r_wdata_q     <= '0;
            r_be_q        <= '0;
            r_wr_ack_q    <= 1'b0;
            r_rd_ack_q    <= 1'b0;
            r_init_done_q <= 1'b0;
            r_data_out_q  <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_init_cnt_q  <= w_init_cnt_d;
            r_lat_cnt_q   <= w_lat_cnt_d;
            r_op_q        <= w_op_d;
            r_addr_q      <= w_addr_d;
            r_wdata_q     <= w_wdata_d;
            r_be_q        <= w_be_d;
            r_wr_ack_q    <= w_wr_ack_d;
            r_rd_ack_q    <= w_rd_ack_d;
            r_init_done_q <= w_init_done_d;
            r_data_out_q  <= w_data_out_d;
        end
    end

    // Write commits on the ACK edge; gating with rst_n drops a write caught by reset.
    assign w_ram_en = (r_state_q == ST_BUSY) || (r_state_q == ST_ACK);
    assign w_ram_we = (r_state_q == ST_ACK && r_op_q == OP_WR && rst_n) ? r_be_q : 2'b00;

    bram_be16 #(
        .ADDR_BITS (ADDR_BITS)
    ) u_bram (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (r_addr_q),
        .i_wdata (r_wdata_q),
        .o_rdata (w_ram_rdata)
    );

    assign sdram_wr_ack    = r_wr_ack_q;
    assign sdram_rd_ack    = r_rd_ack_q;
    assign sdram_init_done = r_init_done_q;
    assign sys_data_out    = r_data_out_q;

endmodule
`default_nettype wire
